// File: rtl/jesd_pkg.sv
// Shared definitions for the JESD204B receive-side ramp checker and the
// matching ramp stimulus generator.
package jesd_pkg;

  // Width of one recovered sample word: samples x converters x resolution.
  function automatic int sample_width(input int samples, input int converters,
                                      input int resolution);
    return samples * converters * resolution;
  endfunction

  // Checker state encoding, visible on the state output.
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_ERRSEEN = 2'd2
  } chk_state_t;

  // Ramp constants shared by generator and checker (default 44-bit word).
  localparam logic [43:0] RAMP_INCR = 44'h11111111111;
  localparam logic [43:0] RAMP_SEED = 44'h12345678abc;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // Count up on inc, stick at all-ones, zero on clr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_sample_checker.sv
// Ramp checker for the recovered JESD204B sample word: finds the ramp,
// locks, tracks it with a free-running expected word, flags mismatches and
// keeps saturating match/error/lock-latency statistics.
module rx_sample_checker
  import jesd_pkg::*;
#(
  parameter int           CONVERTERS    = 4,
  parameter int           RESOLUTION    = 11,
  parameter int           SAMPLES       = 1,
  localparam int          W             = sample_width(SAMPLES, CONVERTERS, RESOLUTION),
  parameter logic [W-1:0] INCR          = RAMP_INCR,
  parameter int           LOCK_COUNT    = 4,
  parameter int           UNLOCK_ERRORS = 3,
  parameter int           CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [W-1:0]         rx_dataout,
  output logic                 locked,
  output logic                 error,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] lock_latency
);

  // Last run values before the transition fires (runs are 4 bits, 1..15).
  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_ERRORS - 1);

  chk_state_t   state_q, state_d;
  logic [3:0]   good_run_q, good_run_d;
  logic [3:0]   bad_run_q, bad_run_d;
  logic [W-1:0] prev_p0;
  logic [W-1:0] expected_p0, expected_d;
  logic         valid_prev;
  logic         error_q, error_d;
  logic         lat_frozen;
  logic         step_ok, data_match;
  logic         match_inc, error_inc, lock_enter;
  logic         lat_inc, lat_clr;

  // Ramp step test (wraps modulo 2^W) and locked-mode compare.
  assign step_ok    = valid_prev && (rx_dataout == prev_p0 + INCR);
  assign data_match = (rx_dataout == expected_p0);

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    expected_d = expected_p0;
    error_d    = 1'b0;
    match_inc  = 1'b0;
    error_inc  = 1'b0;
    lock_enter = 1'b0;
    if (!enable) begin
      state_d    = ST_SEARCH;
      good_run_d = '0;
      bad_run_d  = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (!step_ok) begin
            good_run_d = '0;
          end else if (good_run_q == LOCK_LAST) begin
            state_d    = ST_LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
            expected_d = rx_dataout + INCR;
            lock_enter = 1'b1;
          end else begin
            good_run_d = good_run_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Expected free-runs so bad data can never re-seed it.
          expected_d = expected_p0 + INCR;
          if (data_match) begin
            match_inc = 1'b1;
          end else begin
            error_d   = 1'b1;
            error_inc = 1'b1;
            bad_run_d = 4'd1;
            if (UNLOCK_ERRORS == 1) begin
              state_d    = ST_SEARCH;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              state_d = ST_ERRSEEN;
            end
          end
        end
        ST_ERRSEEN: begin
          expected_d = expected_p0 + INCR;
          if (data_match) begin
            match_inc = 1'b1;
            bad_run_d = '0;
            state_d   = ST_LOCKED;
          end else begin
            error_d   = 1'b1;
            error_inc = 1'b1;
            if (bad_run_q == UNLOCK_LAST) begin
              state_d    = ST_SEARCH;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              bad_run_d = bad_run_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = ST_SEARCH;
          good_run_d = '0;
          bad_run_d  = '0;
        end
      endcase
    end
  end

  // FSM state and run-length registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SEARCH;
      good_run_q <= '0;
      bad_run_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      error_q    <= error_d;
    end
  end

  // Sample history: previous word, its validity, and the tracked expected word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_p0     <= '0;
      valid_prev  <= 1'b0;
      expected_p0 <= '0;
    end else begin
      if (enable) begin
        prev_p0 <= rx_dataout;
      end
      valid_prev  <= enable;
      expected_p0 <= expected_d;
    end
  end

  // Latency counting restarts on enable rising or clear; stops at first lock.
  assign lat_clr = clear || (enable && !valid_prev);
  assign lat_inc = enable && !lat_frozen;

  // Freeze flag for the lock-latency counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_frozen <= 1'b0;
    end else if (lock_enter) begin
      lat_frozen <= 1'b1;
    end else if (lat_clr) begin
      lat_frozen <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match_inc),
    .clr   (clear),
    .count (match_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_error_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (error_inc),
    .clr   (clear),
    .count (error_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_latency_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (lat_inc),
    .clr   (lat_clr),
    .count (lock_latency)
  );

  assign state  = state_q;
  assign locked = (state_q != ST_SEARCH);
  assign error  = error_q;

endmodule

// File: tb/tb_rx_sample_checker.sv
// Scoreboard bench for rx_sample_checker: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one entry per clock.
module tb_rx_sample_checker;
  import jesd_pkg::*;

  localparam int W = 44;
  localparam int X = -1;   // field not checked

  logic          clock, reset, enable, clear;
  logic [W-1:0]  rx_dataout;
  logic          locked, error;
  logic [1:0]    state;
  logic [15:0]   match_count, error_count, lock_latency;
  logic          s_locked, s_error;
  logic [1:0]    s_state;
  logic [3:0]    s_match_count, s_error_count, s_lock_latency;

  typedef struct {
    bit    inst;
    string tag;
    int    st;
    int    lk;
    int    er;
    int    mc;
    int    ec;
    int    lt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  rx_sample_checker dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .rx_dataout   (rx_dataout),
    .locked       (locked),
    .error        (error),
    .state        (state),
    .match_count  (match_count),
    .error_count  (error_count),
    .lock_latency (lock_latency)
  );

  rx_sample_checker #(.CNT_WIDTH(4)) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .rx_dataout   (rx_dataout),
    .locked       (s_locked),
    .error        (s_error),
    .state        (s_state),
    .match_count  (s_match_count),
    .error_count  (s_error_count),
    .lock_latency (s_lock_latency)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // k-th word of the reference ramp, modulo 2^44.
  function automatic logic [W-1:0] r(input int k);
    logic [W-1:0] kk;
    kk = W'(k);
    return RAMP_SEED + kk * RAMP_INCR;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic exp_t mk(input bit inst, input string tag, input int st,
                              input int lk, input int er, input int mc,
                              input int ec, input int lt);
    exp_t e;
    e.inst = inst; e.tag = tag; e.st = st; e.lk = lk;
    e.er = er; e.mc = mc; e.ec = ec; e.lt = lt;
    return e;
  endfunction

  function automatic void cmp(input string tag, input string fld,
                              input int act, input int req);
    if (req < 0) return;
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, req);
    end
  endfunction

  function automatic void cmp_main(input exp_t e);
    cmp(e.tag, "state",        int'(state),        e.st);
    cmp(e.tag, "locked",       int'(locked),       e.lk);
    cmp(e.tag, "error",        int'(error),        e.er);
    cmp(e.tag, "match_count",  int'(match_count),  e.mc);
    cmp(e.tag, "error_count",  int'(error_count),  e.ec);
    cmp(e.tag, "lock_latency", int'(lock_latency), e.lt);
  endfunction

  function automatic void cmp_sat(input exp_t e);
    cmp(e.tag, "state",        int'(s_state),        e.st);
    cmp(e.tag, "locked",       int'(s_locked),       e.lk);
    cmp(e.tag, "error",        int'(s_error),        e.er);
    cmp(e.tag, "match_count",  int'(s_match_count),  e.mc);
    cmp(e.tag, "error_count",  int'(s_error_count),  e.ec);
    cmp(e.tag, "lock_latency", int'(s_lock_latency), e.lt);
  endfunction

  // Apply one word for the next rising edge and queue what must follow it.
  task automatic step(input logic [W-1:0] d, input logic en, input logic clr,
                      input exp_t e);
    @(negedge clock);
    rx_dataout = d;
    enable     = en;
    clear      = clr;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.inst) cmp_sat(e);
        else        cmp_main(e);
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; rx_dataout = '0;
    repeat (3) @(posedge clock);
    #1;
    cmp_main(mk(0, "reset", 0, 0, 0, 0, 0, 0));
    cmp_sat(mk(1, "reset_sat", 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;

    // Lock on the reference ramp: locked after the fifth word.
    step(44'h12345678abc, 1, 0, mk(0, "lock0", 0, 0, 0, 0, 0, 0));
    step(44'h23456789bcd, 1, 0, mk(0, "lock1", 0, 0, 0, 0, 0, 1));
    step(44'h3456789acde, 1, 0, mk(0, "lock2", 0, 0, 0, X, X, 2));
    step(44'h456789abdef, 1, 0, mk(0, "lock3", 0, 0, 0, X, X, 3));
    step(44'h56789abcf00, 1, 0, mk(0, "lock4", 1, 1, 0, 0, 0, 4));

    // Single corrupted word, then the ramp carries on matching.
    step(r(5),  1, 0, mk(0, "match5", 1, 1, 0, 1, 0, 4));
    step(44'h0, 1, 0, mk(0, "err6",   2, 1, 1, 1, 1, 4));
    step(r(7),  1, 0, mk(0, "recov7", 1, 1, 0, 2, 1, 4));
    step(r(8),  1, 0, mk(0, "match8", 1, 1, 0, 3, 1, 4));

    // Clear, then three garbage words drop lock; ramp resumes and relocks.
    step(r(9),    1, 1, mk(0, "clear9", 1, 1, 0, 0, 0, 0));
    step(44'h0,   1, 0, mk(0, "bad10",  2, 1, 1, 0, 1, 1));
    step(44'habc, 1, 0, mk(0, "bad11",  2, 1, 1, 0, 2, 2));
    step(44'h0,   1, 0, mk(0, "bad12",  0, 0, 1, 0, 3, 3));
    step(r(13),   1, 0, mk(0, "resync13", 0, 0, 0, 0, 3, 4));
    for (int k = 14; k <= 16; k++)
      step(r(k), 1, 0, mk(0, $sformatf("resync%0d", k), 0, 0, 0, 0, 3, k - 9));
    step(r(17),   1, 0, mk(0, "relock17", 1, 1, 0, 0, 3, 8));

    // Enable dropped for one cycle: SEARCH, counters held, latency restarts.
    step(r(18), 0, 0, mk(0, "endrop18", 0, 0, 0, 0, 3, 8));
    step(r(19), 1, 0, mk(0, "enrise19", 0, 0, 0, 0, 3, 0));
    for (int k = 20; k <= 22; k++)
      step(r(k), 1, 0, mk(0, $sformatf("search%0d", k), 0, 0, 0, 0, 3, k - 19));
    step(r(23), 1, 0, mk(0, "relock23", 1, 1, 0, 0, 3, 4));

    // Clear coincident with a mismatch: pulse still seen, count reads 0.
    step(44'h0, 1, 1, mk(0, "clrerr24", 2, 1, 1, 0, 0, 0));
    step(r(25), 1, 0, mk(0, "match25",  1, 1, 0, 1, 0, 1));

    // Ramp crossing 2^44 locks cleanly.
    step(44'h0,           0, 0, mk(0, "endrop26", 0, 0, 0, 1, 0, 1));
    step(44'hEEEEEEEEEEE, 1, 0, mk(0, "wrap0", 0, 0, 0, 1, 0, 0));
    step(44'hFFFFFFFFFFF, 1, 0, mk(0, "wrap1", 0, 0, 0, 1, 0, 1));
    step(44'h11111111110, 1, 0, mk(0, "wrap2", 0, 0, 0, 1, 0, 2));
    step(44'h22222222221, 1, 0, mk(0, "wrap3", 0, 0, 0, 1, 0, 3));
    step(44'h33333333332, 1, 0, mk(0, "wrap4", 1, 1, 0, 1, 0, 4));
    step(44'h44444444443, 1, 0, mk(0, "wrap5", 1, 1, 0, 2, 0, 4));

    // Asynchronous reset while locked clears outputs without a clock.
    @(posedge clock);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    cmp_main(mk(0, "async_rst", 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;

    // Saturation on the 4-bit instance: full SEARCH, then 20 error/match pairs.
    for (int k = 0; k <= 3; k++)
      step(r(k), 1, 0, mk(1, $sformatf("sat_search%0d", k), 0, 0, 0, 0, 0, k));
    step(r(4), 1, 0, mk(1, "sat_lock", 1, 1, 0, 0, 0, 4));
    for (int i = 0; i < 20; i++) begin
      step(44'h0, 1, 0, mk(1, $sformatf("sat_bad%0d", i), 2, 1, 1,
                           sat15(i), sat15(i + 1), 4));
      step(r(6 + 2 * i), 1, 0, mk(1, $sformatf("sat_good%0d", i), 1, 1, 0,
                                  sat15(i + 1), sat15(i + 1), 4));
    end

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sample_checker.md
Name: rx_sample_checker

Overview:
- Sits directly downstream of the JESD204B transport/link top and consumes its recovered sample word rx_dataout.
- Checks rx_dataout against the arithmetic ramp used as link stimulus: each word is the previous word plus a fixed increment, modulo 2^W.
- Self-synchronises to the unknown link latency, reports lock, flags mismatches and keeps saturating statistics for the bench and for on-chip link bring-up.

Parameters:
- CONVERTERS, 4, number of converters.
- RESOLUTION, 11, bits per converter sample.
- SAMPLES, 1, samples per frame.
- INCR, 44'h11111111_111, ramp increment; width W = SAMPLES*CONVERTERS*RESOLUTION (localparam, 44 by default).
- LOCK_COUNT, 4, consecutive good steps needed to lock (1..15).
- UNLOCK_ERRORS, 3, consecutive mismatches that drop lock (1..15).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is reset while it is low.
- enable  in  1  checking enabled; while low the checker is forced to SEARCH.
- clear  in  1  synchronous; zeroes match_count, error_count and lock_latency.
- rx_dataout  in  W  recovered sample word, one word per clock.
- locked  out  1  high while in the LOCKED state.
- error  out  1  one-cycle pulse for each mismatch while LOCKED.
- state  out  2  SEARCH=0, LOCKED=1, ERRSEEN=2.
- match_count  out  CNT_WIDTH  number of matching words while LOCKED/ERRSEEN; saturates.
- error_count  out  CNT_WIDTH  number of mismatches; saturates.
- lock_latency  out  CNT_WIDTH  cycles from enable rising to the first lock; saturates.

Behaviour:
- Reset values: all outputs 0, state SEARCH, internal registers 0.
- rx_dataout is registered into prev every cycle while enable is high.
- A valid_prev flag is set on the first enabled cycle and cleared whenever enable is low.
- SEARCH state:
  - step_ok = valid_prev && (rx_dataout == prev + INCR); the add is W bits and wraps, with no carry out.
  - good_run increments on step_ok and resets to 0 otherwise.
  - When good_run reaches LOCK_COUNT: go to LOCKED, load expected = rx_dataout + INCR, and set locked at the same edge.
  - Lock latency: locked is visible one cycle after the clock that sampled the (LOCK_COUNT+1)th consecutive ramp word.
- LOCKED state:
  - Compare rx_dataout against expected; expected += INCR every cycle regardless of the outcome, so it never re-seeds from bad data.
  - Match: match_count++.
  - Mismatch: error pulses high for 1 cycle, error_count++, bad_run = 1, go to ERRSEEN; locked stays high.
- ERRSEEN state:
  - Match: bad_run = 0, return to LOCKED.
  - Mismatch: error pulse, error_count++, bad_run++.
  - When bad_run reaches UNLOCK_ERRORS: go to SEARCH, locked = 0, good_run = 0.
  - With UNLOCK_ERRORS = 1, the first mismatch in LOCKED goes directly to SEARCH.
- lock_latency:
  - Counts cycles from the first enabled cycle.
  - Freezes at the first LOCKED entry.
  - Restarts only when enable rises again or clear is asserted.
- enable low: state SEARCH, locked = 0, error = 0; counters hold their values.
- clear together with a mismatch in the same cycle: clear wins, and the counter reads 0 the next cycle; the error pulse is still emitted.
- All counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Reset asserted mid-operation: everything returns to its reset values immediately (asynchronous). After reset is released, a full SEARCH is required to lock again.

Decomposition:
- Shared package jesd_pkg holds:
  - the W width function;
  - the checker state encoding (SEARCH/LOCKED/ERRSEEN);
  - default INCR and SEED constants, shared with the stimulus generator.
- One sub-module, sat_counter (parameter width; inputs inc and clr; saturating; asynchronous active-low reset), instantiated three times.

Test Plan:
1. Lock: after reset release, drive 0x12345678abc, 0x23456789bcd, 0x3456789acde, 0x456789abdef, 0x56789abcf00 on consecutive cycles.
   - locked = 1 the cycle after 0x56789abcf00 is sampled; state = 1; error_count = 0.
2. Single error: after lock, replace one word with 0x0.
   - One-cycle error pulse; error_count = 1; state 2 then back to 1; locked stays 1.
   - The next correct ramp word matches, because expected was not re-seeded.
3. Unlock: after lock, drive 3 consecutive garbage words.
   - error_count = 3; state = 0 and locked = 0 after the third.
   - Resuming the ramp relocks after 5 ramp words.
4. Wrap: drive the sequence 0xEEEEEEEEEEE, 0xFFFFFFFFFFF, 0x11111111110, 0x22222222221, 0x33333333332.
   - Locks with no error; confirms the modulo-2^44 add.
5. Reset and enable:
   - Assert reset (low) while LOCKED: all outputs read 0 immediately.
   - Separately, drop enable for 1 cycle: state = 0 and counters are retained.
   - Pulse clear: match_count = error_count = 0 next cycle.
6. Saturation: with CNT_WIDTH = 4, inject 20 errors.
   - error_count holds at 15 and does not wrap.
